// File: rtl/mcycle_ctrl.sv
// Sequencer for the multi-cycle MUL/DIV unit: shift-add multiplier and restoring
// divider, one bit per cycle for WIDTH cycles, with Busy stall and one-cycle Done.
module mcycle_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               w_accept, w_last;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_orig1, r_rem;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_result1, r_result2;

  logic               w_neg1, w_neg2;
  logic [WIDTH-1:0]   w_abs1, w_abs2;
  logic [WIDTH:0]     w_sum, w_shift;
  logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
  logic [WIDTH-1:0]   w_diff, w_rem_nxt, w_quot_nxt;
  logic               w_ge;
  logic [WIDTH-1:0]   w_res1, w_res2;

  assign w_last = (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_accept    = 1'b1;
          Busy        = 1'b1;
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        Busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        if (Start) begin
          w_accept    = 1'b1;
          Busy        = 1'b1;
          w_state_nxt = S_COMPUTE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Signed operands are iterated as magnitudes; signs are reapplied at completion.
  always_comb begin
    w_neg1 = MCycleOp[0] & Operand1[WIDTH-1];
    w_neg2 = MCycleOp[0] & Operand2[WIDTH-1];
    w_abs1 = w_neg1 ? -Operand1 : Operand1;
    w_abs2 = w_neg2 ? -Operand2 : Operand2;
  end

  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : '0)};
    w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  end

  // Remainder stays below the divisor, so only the shifted trial needs WIDTH+1 bits.
  always_comb begin
    w_shift    = {r_rem, r_acc[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_b});
    w_diff     = w_shift[WIDTH-1:0] - r_b;
    w_rem_nxt  = w_ge ? w_diff : w_shift[WIDTH-1:0];
    w_quot_nxt = {r_acc[WIDTH-2:0], w_ge};
  end

  always_comb begin
    w_res1 = w_prod[WIDTH-1:0];
    w_res2 = w_prod[2*WIDTH-1:WIDTH];
    if (r_op[1]) begin
      if (r_b == '0) begin
        w_res1 = '1;
        w_res2 = r_orig1;
      end else begin
        w_res1 = r_neg_q ? -w_quot_nxt : w_quot_nxt;
        w_res2 = r_neg_r ? -w_rem_nxt : w_rem_nxt;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_orig1   <= '0;
      r_rem     <= '0;
      r_acc     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result1 <= '0;
      r_result2 <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= MCycleOp;
      r_a     <= w_abs1;
      r_b     <= w_abs2;
      r_orig1 <= Operand1;
      r_rem   <= '0;
      r_acc   <= {{WIDTH{1'b0}}, (MCycleOp[1] ? w_abs1 : w_abs2)};
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
    end else if (r_state == S_COMPUTE) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_op[1]) begin
        r_acc <= {r_acc[2*WIDTH-1:WIDTH], w_quot_nxt};
        r_rem <= w_rem_nxt;
      end else begin
        r_acc <= w_acc_nxt;
      end
      if (w_last) begin
        r_result1 <= w_res1;
        r_result2 <= w_res2;
      end
    end
  end

  assign Result1 = r_result1;
  assign Result2 = r_result2;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed self-checking bench for mcycle_ctrl (WIDTH=32): arithmetic results,
// latency, Busy/Done timing, ignored mid-compute Start, back-to-back and reset abort.
module tb_mcycle_ctrl;

  logic        CLK, Reset, Start, Busy, Done;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1, Operand2, Result1, Result2;
  int          n_cmp, n_bad;

  mcycle_ctrl #(.WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Caller is positioned at a negedge; returns at the negedge where Done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, output int lat, output bit held);
    logic [31:0] h1, h2;
    h1 = Result1; h2 = Result2; held = 1'b1;
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1;
    n_cmp++;
    if (Busy !== 1'b1) begin n_bad++; $display("FAIL busy_at_start: got %b expected 1", Busy); end
    @(posedge CLK); @(negedge CLK);
    Start = 1'b0; Operand1 = 32'hDEADBEEF; Operand2 = 32'h0BADF00D; MCycleOp = 2'b01;
    lat = 1;
    while (Done !== 1'b1 && lat < 100) begin
      if (Result1 !== h1 || Result2 !== h2) held = 1'b0;
      if (lat == pulse_at) begin
        Start = 1'b1; MCycleOp = 2'b10; Operand1 = 32'h55; Operand2 = 32'h3;
        #1;
        n_cmp++;
        if (Busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid_compute: got %b expected 1", Busy); end
      end
      @(negedge CLK);
      Start = 1'b0;
      lat++;
    end
    if (lat >= 100) begin n_bad++; n_cmp++; $display("FAIL done_timeout: got no Done within %0d cycles expected 33", lat); end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    repeat (2) @(negedge CLK);
    n_cmp += 4;
    if (Busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    if (Done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b expected 0", Done); end
    if (Result1 !== 32'h0) begin n_bad++; $display("FAIL reset_r1: got %h expected 0", Result1); end
    if (Result2 !== 32'h0) begin n_bad++; $display("FAIL reset_r2: got %h expected 0", Result2); end
    Reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_umul();
    int lat; bit held;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, held);
    n_cmp += 4;
    if (lat !== 33)              begin n_bad++; $display("FAIL umul_latency: got %0d expected 33", lat); end
    if (Result2 !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL umul_r2: got %h expected fffffffe", Result2); end
    if (Result1 !== 32'h00000001) begin n_bad++; $display("FAIL umul_r1: got %h expected 00000001", Result1); end
    if (Busy !== 1'b0)           begin n_bad++; $display("FAIL umul_busy_in_done: got %b expected 0", Busy); end
    @(negedge CLK);
    n_cmp += 2;
    if (Done !== 1'b0) begin n_bad++; $display("FAIL umul_done_width: got %b expected 0", Done); end
    if (Result1 !== 32'h00000001) begin n_bad++; $display("FAIL umul_r1_held_idle: got %h expected 00000001", Result1); end
  endtask

  task automatic test_smul();
    int lat; bit held;
    run_op(2'b01, 32'hFFFFFFF9, 32'h00000003, 0, lat, held);
    n_cmp += 2;
    if (Result2 !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL smul_r2: got %h expected ffffffff", Result2); end
    if (Result1 !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL smul_r1: got %h expected ffffffeb", Result1); end
    @(negedge CLK);
  endtask

  task automatic test_sdiv();
    int lat; bit held;
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, 0, lat, held);
    n_cmp += 2;
    if (Result1 !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL sdiv_q: got %h expected fffffffd", Result1); end
    if (Result2 !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL sdiv_r: got %h expected ffffffff", Result2); end
    @(negedge CLK);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, lat, held);
    n_cmp += 2;
    if (Result1 !== 32'h80000000) begin n_bad++; $display("FAIL sdiv_ovf_q: got %h expected 80000000", Result1); end
    if (Result2 !== 32'h00000000) begin n_bad++; $display("FAIL sdiv_ovf_r: got %h expected 00000000", Result2); end
    @(negedge CLK);
  endtask

  task automatic test_udiv();
    int lat; bit held;
    run_op(2'b10, 32'd100, 32'd7, 0, lat, held);
    n_cmp += 2;
    if (Result1 !== 32'd14) begin n_bad++; $display("FAIL udiv_q: got %h expected 0000000e", Result1); end
    if (Result2 !== 32'd2)  begin n_bad++; $display("FAIL udiv_r: got %h expected 00000002", Result2); end
    @(negedge CLK);
    run_op(2'b10, 32'h12345678, 32'h0, 0, lat, held);
    n_cmp += 3;
    if (lat !== 33)               begin n_bad++; $display("FAIL divzero_latency: got %0d expected 33", lat); end
    if (Result1 !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divzero_q: got %h expected ffffffff", Result1); end
    if (Result2 !== 32'h12345678) begin n_bad++; $display("FAIL divzero_r: got %h expected 12345678", Result2); end
    @(negedge CLK);
    run_op(2'b11, 32'hFFFFFF9C, 32'h0, 0, lat, held);
    n_cmp += 2;
    if (Result1 !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL sdivzero_q: got %h expected ffffffff", Result1); end
    if (Result2 !== 32'hFFFFFF9C) begin n_bad++; $display("FAIL sdivzero_r: got %h expected ffffff9c", Result2); end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int lat; bit held;
    run_op(2'b00, 32'd3, 32'd5, 5, lat, held);
    n_cmp += 3;
    if (lat !== 33)        begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected 33", lat); end
    if (Result1 !== 32'd15) begin n_bad++; $display("FAIL b2b_first_r1: got %h expected 0000000f", Result1); end
    if (Result2 !== 32'd0)  begin n_bad++; $display("FAIL b2b_first_r2: got %h expected 00000000", Result2); end
    Start = 1'b1;
    #1;
    n_cmp++;
    if ({Done, Busy} !== 2'b11) begin n_bad++; $display("FAIL b2b_done_busy: got %b expected 11", {Done, Busy}); end
    run_op(2'b10, 32'd100, 32'd7, 0, lat, held);
    n_cmp += 4;
    if (lat !== 33)         begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
    if (held !== 1'b1)      begin n_bad++; $display("FAIL b2b_results_held: got %b expected 1", held); end
    if (Result1 !== 32'd14) begin n_bad++; $display("FAIL b2b_second_q: got %h expected 0000000e", Result1); end
    if (Result2 !== 32'd2)  begin n_bad++; $display("FAIL b2b_second_r: got %h expected 00000002", Result2); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int lat, dones; bit held;
    Start = 1'b1; MCycleOp = 2'b10; Operand1 = 32'd1000; Operand2 = 32'd3;
    @(posedge CLK); @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    Reset = 1'b1;
    #1;
    n_cmp += 4;
    if (Busy !== 1'b0)     begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
    if (Done !== 1'b0)     begin n_bad++; $display("FAIL rstmid_done: got %b expected 0", Done); end
    if (Result1 !== 32'h0) begin n_bad++; $display("FAIL rstmid_r1: got %h expected 0", Result1); end
    if (Result2 !== 32'h0) begin n_bad++; $display("FAIL rstmid_r2: got %h expected 0", Result2); end
    @(negedge CLK);
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done === 1'b1 || Busy === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", dones); end
    run_op(2'b00, 32'd6, 32'd7, 0, lat, held);
    n_cmp += 3;
    if (lat !== 33)         begin n_bad++; $display("FAIL rstmid_mul_latency: got %0d expected 33", lat); end
    if (Result1 !== 32'd42) begin n_bad++; $display("FAIL rstmid_mul_r1: got %h expected 0000002a", Result1); end
    if (Result2 !== 32'd0)  begin n_bad++; $display("FAIL rstmid_mul_r2: got %h expected 00000000", Result2); end
    @(negedge CLK);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_umul();
    test_smul();
    test_sdiv();
    test_udiv();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
